regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file for the Mini-MIPS datapath, with NR asynchronous read ports and two synchronous write ports.
- Write port 0 takes ALU/load writeback. Write port 1 takes long-latency completions (mult/div unit).
- An integrated per-register busy scoreboard stalls consumers of registers with pending long-latency writes.
- Optional write-to-read bypass; register 0 hardwired to zero.

Parameters:
- W, 5, register address width; depth = 2**W.
- D, 32, data width.
- NR, 2, number of read ports (1..4).
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- ra  input  NR*W  read addresses; port k uses bits [k*W +: W].
- dout  output  NR*D  read data; port k uses bits [k*D +: D].
- busy  output  NR  busy[k]=1 when RM[ra_k] has a pending long-latency write.
- we0  input  1  write enable, port 0.
- wa0  input  W  write address, port 0.
- wd0  input  D  write data, port 0.
- we1  input  1  write enable, port 1 (long-latency completion).
- wa1  input  W  write address, port 1.
- wd1  input  D  write data, port 1.
- sb_set  input  1  mark register sb_addr busy (long-latency op issued).
- sb_addr  input  W  register to mark busy.
- collide  output  1  registered pulse: both ports wrote the same nonzero address last cycle.

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - All registers are cleared to 0.
  - All busy bits are cleared.
  - collide is cleared to 0.
  - rst overrides every write and every sb_set in the same cycle.
- Writes commit on the rising edge of clk: RM[wa0]<=wd0 if we0; RM[wa1]<=wd1 if we1.
- Writes addressed to register 0 are ignored on both ports; RM[0] stays 0 permanently.
- Write collision (we0 & we1 & wa0==wa1 & wa0!=0):
  - Port 0 data is stored; port 1 data is discarded.
  - collide=1 for exactly the next cycle.
  - The busy bit is still cleared.
- Reads are combinational, zero latency: dout_k = RM[ra_k].
- ra_k==0 always reads 0 and busy[k]=0.
- Bypass, BYPASS=1, ra_k!=0:
  - If we0 & wa0==ra_k, dout_k=wd0.
  - Else if we1 & wa1==ra_k, dout_k=wd1.
  - Else dout_k=RM[ra_k].
- BYPASS=0: the written value becomes visible the cycle after the edge.
- Scoreboard, one bit per register (bit 0 tied 0), updated at the clock edge:
  - sb_set & sb_addr!=0 sets SB[sb_addr].
  - we1 clears SB[wa1].
  - If the set and the clear target the same register in the same cycle, the set wins (new issue overrides the old completion).
  - we0 does not affect the scoreboard.
  - sb_set to an already-busy register keeps it busy; no error is raised.
- busy[k] is combinational from SB[ra_k].
  - With BYPASS=1, busy[k] is forced to 0 when we1 & wa1==ra_k & !(sb_set & sb_addr==ra_k), so a consumer may proceed in the completion cycle.
  - With BYPASS=0, busy[k] is not forced.
- Read ports are fully independent; any number of them may address the same register.

Test Plan:
- Reset then read: rst=1 for 1 cycle with we0=1,wa0=3,wd0=0xAAAA_AAAA → RM[3]=0, all busy=0, collide=0.
- Write then read: write wd0=0x1234_5678 to r5 with BYPASS=1, ra0=5 in the same cycle → dout0=0x1234_5678 combinationally; after the edge, ra1=5 also reads 0x1234_5678.
- Register zero: we0=1,wa0=0,wd0=0xFFFF_FFFF and we1=1,wa1=0 → dout reads 0 on all ports; busy stays 0 even after sb_set with sb_addr=0.
- Scoreboard flow:
  - sb_set for r7 → busy for ra=7 is 1 on the next cycle.
  - 3 idle cycles → busy remains 1.
  - we1,wa1=7,wd1=0x0000_00C8 → busy=0 and dout=0xC8 in that cycle (BYPASS=1); SB[7]=0 after the edge.
- Set/clear race: SB[9]=1; sb_set for r9 and we1 to r9 in the same cycle → SB[9] remains 1, RM[9]=wd1.
- Collision: we0/we1 both to r4 with 0x11 and 0x22 → RM[4]=0x11, collide=1 for exactly one cycle, then 0.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with a long-latency busy scoreboard and optional write bypass
module regfile_mp_sb #(
   parameter int W      = 5,
   parameter int D      = 32,
   parameter int NR     = 2,
   parameter int BYPASS = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NR*W-1:0] ra,
   output logic [NR*D-1:0] dout,
   output logic [NR-1:0]   busy,
   input  logic            we0,
   input  logic [W-1:0]    wa0,
   input  logic [D-1:0]    wd0,
   input  logic            we1,
   input  logic [W-1:0]    wa1,
   input  logic [D-1:0]    wd1,
   input  logic            sb_set,
   input  logic [W-1:0]    sb_addr,
   output logic            collide
);
   localparam int N  = 2**W;
   localparam bit BP = (BYPASS != 0);

   logic [D-1:0] rm [N];
   logic [N-1:0] sb;
   logic [W-1:0] a;

   // Register array, scoreboard and collision flag; port 0 is written last so it wins a collision,
   // and the scoreboard set is applied after the completion clear so a new issue wins a race
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) rm[i] <= '0;
         sb      <= '0;
         collide <= 1'b0;
      end else begin
         if (we1 && wa1 != '0) rm[wa1] <= wd1;
         if (we0 && wa0 != '0) rm[wa0] <= wd0;
         if (we1) sb[wa1] <= 1'b0;
         if (sb_set && sb_addr != '0) sb[sb_addr] <= 1'b1;
         collide <= we0 && we1 && wa0 == wa1 && wa0 != '0;
      end
   end

   // Combinational read ports with optional same-cycle forwarding and busy release on completion
   always_comb begin
      dout = '0;
      busy = '0;
      a    = '0;
      for (int k = 0; k < NR; k++) begin
         a = ra[k*W +: W];
         dout[k*D +: D] = (a == '0)                     ? '0  :
                          (BP && we0 && wa0 == a)       ? wd0 :
                          (BP && we1 && wa1 == a)       ? wd1 : rm[a];
         busy[k] = a != '0 && sb[a] &&
                   !(BP && we1 && wa1 == a && !(sb_set && sb_addr == a));
      end
   end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: scoreboard-driven bench for regfile_mp_sb (W=5, D=32, NR=2, BYPASS=1)
module tb_regfile_mp_sb;
   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  ra;
   logic [63:0] dout;
   logic [1:0]  busy;
   logic        we0, we1, sb_set;
   logic [4:0]  wa0, wa1, sb_addr;
   logic [31:0] wd0, wd1;
   logic        collide;

   int n_tests = 0;
   int n_fail  = 0;
   logic [63:0] expq [$];

   logic [31:0] rm_m [32];
   logic [31:0] sb_m;
   logic        col_m;

   regfile_mp_sb #(.W(5), .D(32), .NR(2), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .ra(ra), .dout(dout), .busy(busy),
      .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
      .sb_set(sb_set), .sb_addr(sb_addr), .collide(collide)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [63:0] e);
      expq.push_back(e);
   endtask

   task automatic observe(input string tag, input logic [63:0] obs);
      if (expq.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: got %h with no expected value queued", tag, obs);
      end else check(tag, obs, expq.pop_front());
   endtask

   task automatic idle();
      rst = 0; we0 = 0; we1 = 0; sb_set = 0;
      wa0 = 0; wa1 = 0; sb_addr = 0; wd0 = 0; wd1 = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (we0 && wa0 == a) return wd0;
      if (we1 && wa1 == a) return wd1;
      return rm_m[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      if (a == 0 || !sb_m[a]) return 1'b0;
      return !(we1 && wa1 == a && !(sb_set && sb_addr == a));
   endfunction

   task automatic model_edge();
      if (rst) begin
         for (int i = 0; i < 32; i++) rm_m[i] = 0;
         sb_m  = 0;
         col_m = 0;
      end else begin
         col_m = we0 && we1 && wa0 == wa1 && wa0 != 0;
         if (we0 && wa0 != 0) rm_m[wa0] = wd0;
         if (we1 && wa1 != 0 && !(we0 && wa0 == wa1)) rm_m[wa1] = wd1;
         if (we1 && !(sb_set && sb_addr == wa1)) sb_m[wa1] = 1'b0;
         if (sb_set && sb_addr != 0) sb_m[sb_addr] = 1'b1;
      end
   endtask

   initial begin
      idle();
      ra = 0;
      // reset overrides a write and an issue in the same cycle
      rst = 1; we0 = 1; wa0 = 3; wd0 = 32'hAAAA_AAAA; sb_set = 1; sb_addr = 3;
      tick();
      idle();
      ra = {5'd3, 5'd3};
      #1;
      push(64'h0); observe("reset_dout", dout);
      push(64'h0); observe("reset_busy", {62'h0, busy});
      push(64'h0); observe("reset_collide", {63'h0, collide});

      // write with same-cycle bypass, then read from the other port after the edge
      we0 = 1; wa0 = 5; wd0 = 32'h1234_5678; ra = {5'd0, 5'd5};
      #1;
      push(64'h1234_5678); observe("bypass_wd0", dout);
      tick();
      idle();
      ra = {5'd5, 5'd0};
      #1;
      push(64'h1234_5678_0000_0000); observe("stored_r5", dout);

      // register zero ignores writes and issues
      we0 = 1; wa0 = 0; wd0 = 32'hFFFF_FFFF; we1 = 1; wa1 = 0; wd1 = 32'hFFFF_FFFF;
      sb_set = 1; sb_addr = 0; ra = {5'd0, 5'd0};
      #1;
      push(64'h0); observe("r0_write_dout", dout);
      tick();
      idle();
      #1;
      push(64'h0); observe("r0_after_dout", dout);
      push(64'h0); observe("r0_after_busy", {62'h0, busy});

      // scoreboard issue, hold, completion with bypass release
      sb_set = 1; sb_addr = 7; ra = {5'd7, 5'd7};
      #1;
      push(64'h0); observe("sb7_issue_cycle", {62'h0, busy});
      tick();
      idle();
      #1;
      push(64'h3); observe("sb7_busy", {62'h0, busy});
      for (int i = 0; i < 3; i++) begin
         tick();
         push(64'h3); observe("sb7_hold", {62'h0, busy});
      end
      we1 = 1; wa1 = 7; wd1 = 32'h0000_00C8;
      #1;
      push(64'h0); observe("sb7_release_busy", {62'h0, busy});
      push(64'h0000_00C8_0000_00C8); observe("sb7_release_dout", dout);
      tick();
      idle();
      #1;
      push(64'h0); observe("sb7_cleared", {62'h0, busy});
      push(64'h0000_00C8_0000_00C8); observe("sb7_stored", dout);

      // set/clear race on r9: the new issue wins
      sb_set = 1; sb_addr = 9; ra = {5'd0, 5'd9};
      tick();
      idle();
      #1;
      push(64'h1); observe("sb9_busy", {62'h0, busy});
      sb_set = 1; sb_addr = 9; we1 = 1; wa1 = 9; wd1 = 32'h0000_0055;
      #1;
      push(64'h1); observe("race_busy_now", {62'h0, busy});
      push(64'h55); observe("race_dout_now", dout);
      tick();
      idle();
      #1;
      push(64'h1); observe("race_busy_after", {62'h0, busy});
      push(64'h55); observe("race_rm9", dout);

      // collision on r4: port 0 wins, one-cycle pulse
      we0 = 1; wa0 = 4; wd0 = 32'h11; we1 = 1; wa1 = 4; wd1 = 32'h22; ra = {5'd0, 5'd4};
      #1;
      push(64'h11); observe("col_bypass", dout);
      push(64'h0); observe("col_before", {63'h0, collide});
      tick();
      idle();
      #1;
      push(64'h1); observe("col_pulse", {63'h0, collide});
      push(64'h11); observe("col_rm4", dout);
      tick();
      push(64'h0); observe("col_drop", {63'h0, collide});

      // both ports to r0 must not raise collide
      we0 = 1; we1 = 1; wa0 = 0; wa1 = 0;
      tick();
      idle();
      push(64'h0); observe("col_r0", {63'h0, collide});

      // randomised traffic against the reference model
      rst = 1;
      model_edge();
      tick();
      idle();
      for (int c = 0; c < 300; c++) begin
         rst     = ($urandom_range(39) == 0);
         we0     = 1'($urandom_range(1));
         we1     = 1'($urandom_range(1));
         sb_set  = 1'($urandom_range(1));
         wa0     = 5'($urandom_range(7));
         wa1     = 5'($urandom_range(7));
         sb_addr = 5'($urandom_range(7));
         wd0     = $urandom;
         wd1     = $urandom;
         ra      = {5'($urandom_range(7)), 5'($urandom_range(7))};
         #1;
         push({32'h0, exp_rd(ra[4:0])});  observe("rnd_dout0", {32'h0, dout[31:0]});
         push({32'h0, exp_rd(ra[9:5])});  observe("rnd_dout1", {32'h0, dout[63:32]});
         push({62'h0, exp_busy(ra[9:5]), exp_busy(ra[4:0])}); observe("rnd_busy", {62'h0, busy});
         push({63'h0, col_m}); observe("rnd_collide", {63'h0, collide});
         model_edge();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
